io_responder: RTL and testbench

Memory-mapped responder for the `io_if` load/store bus: the target end of the ALU's `op_load`/`op_store` path. It accepts one `rd` or `wr` strobe at a time and holds a small word-addressed storage array. After a programmable number of wait states it returns a single-cycle `ack`, driving read data onto the shared `data` bus only during that `ack` cycle. It sits beside `tinyalu` in the top level and replaces the bench-side memory model as a synthesizable target.

---
 rtl/io_responder_pkg.sv | 32 +++
 rtl/io_resp_mem.sv | 53 +++++
 rtl/io_responder.sv | 117 +++++++++++
 tb/tb_io_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// io_responder_pkg
// Shared types and helpers for the io_if load/store responder.
//   io_resp_state_e : responder FSM states (IDLE, WAIT, ACK)
//   io_resp_op_e    : captured operation (READ, WRITE)
//   ST_*            : plain logic constants of the state encoding, used by
//                     the FSM register so older tools see a simple vector
//   addr_in_range() : true when a word address falls inside the array
package io_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } io_resp_state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } io_resp_op_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_ACK  = ACK;

    // Addresses at or above the implemented depth are not folded back
    // into the array; callers use this to suppress the access instead.
    function automatic logic addr_in_range(input int unsigned addr,
                                           input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/io_resp_mem.sv
// io_resp_mem
// Single-port synchronous word array for io_responder, DEPTH x DATA_W.
// Ports:
//   clk, reset_n : clock (rising edge), async active-low reset (read reg only)
//   en           : perform an access this edge
//   we           : 1 = write wdata to addr, 0 = load addr into rdata
//   addr         : full-width word address; out-of-range addresses are
//                  guarded here (writes dropped, reads return 0)
//   wdata        : write data
//   rdata        : registered read data
// The array itself is never reset so its contents survive a reset.
module io_resp_mem
    import io_responder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              hit;

    // The low bits only select a word after the full address has been
    // range-checked, so no out-of-range address can alias into the array.
    assign hit = addr_in_range(32'(addr), DEPTH);
    assign idx = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (en && we && hit) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= hit ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/io_responder.sv
// io_responder
// Memory-mapped target for the io_if load/store bus. Accepts one rd or wr
// strobe while idle, waits WAIT_STATES cycles, then raises ack for one
// cycle; read data is driven onto io_data only during that ack cycle.
// Ports:
//   clk, reset_n : clock (rising edge), async active-low reset
//   io_addr      : word address from the initiator
//   io_rd, io_wr : load / store strobes
//   io_ack       : one-cycle completion
//   io_data      : shared data bus (write data in, read data out on ack)
//   busy         : transaction captured and not yet acked
//   proto_err    : one-cycle pulse when rd and wr were both seen while idle
module io_responder
    import io_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic              io_rd,
    input  logic              io_wr,
    output logic              io_ack,
    inout  wire  [DATA_W-1:0] io_data,
    output logic              busy,
    output logic              proto_err
);

    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]        state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    io_resp_op_e       op_q;

    logic is_idle;
    logic capture;
    logic commit;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign is_idle = (state_q == ST_IDLE);
    assign capture = is_idle && (io_rd ^ io_wr);

    // The array access happens on the edge that enters ACK. With no wait
    // states that is the capture edge itself, so the bus inputs feed the
    // array directly instead of the not-yet-loaded capture registers.
    assign commit    = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) || (capture && ZERO_WAIT);
    assign mem_addr  = is_idle ? io_addr : addr_q;
    assign mem_wdata = is_idle ? io_data : wdata_q;
    assign mem_we    = is_idle ? io_wr : (op_q == WRITE);

    // Transaction FSM: strobes are only looked at in IDLE, so the
    // initiator's repeated pulses during WAIT/ACK never start a new access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_q      <= READ;
            proto_err <= 1'b0;
        end else begin
            proto_err <= is_idle && io_rd && io_wr;
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        addr_q  <= io_addr;
                        op_q    <= io_wr ? WRITE : READ;
                        wdata_q <= io_wr ? io_data : '0;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ZERO_WAIT ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    io_resp_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (commit),
        .we      (mem_we),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rdata   (rdata_q)
    );

    assign io_ack  = (state_q == ST_ACK);
    assign busy    = (state_q == ST_WAIT);
    assign io_data = (io_ack && (op_q == READ)) ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder
// Two responders: A (WAIT_STATES=2, DEPTH=128) and B (WAIT_STATES=0,
// DEPTH=256). A transaction-level model predicts ack/busy/proto_err/data
// from edge arithmetic; a compare process checks every cycle, and directed
// sequences add literal expectations. The data buses are pulled up so an
// undriven bus reads 0xFF.
module tb_io_responder;

    localparam int WS_A = 2;
    localparam int DEPTH_A = 128;
    localparam int WS_B = 0;
    localparam int DEPTH_B = 256;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       rd [2];
    logic       wr [2];
    logic       toe [2];
    logic [7:0] addr [2];
    logic [7:0] tdat [2];
    logic       ack [2];
    logic       busy [2];
    logic       perr [2];

    tri1 [7:0] bus0;
    tri1 [7:0] bus1;
    assign bus0 = toe[0] ? tdat[0] : 8'hzz;
    assign bus1 = toe[1] ? tdat[1] : 8'hzz;

    int ws [2]    = '{WS_A, WS_B};
    int depth [2] = '{DEPTH_A, DEPTH_B};

    int n_cmp = 0;
    int n_fail = 0;

    io_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH_A), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .io_addr(addr[0]), .io_rd(rd[0]), .io_wr(wr[0]),
        .io_ack(ack[0]), .io_data(bus0), .busy(busy[0]), .proto_err(perr[0])
    );

    io_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH_B), .WAIT_STATES(WS_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .io_addr(addr[1]), .io_rd(rd[1]), .io_wr(wr[1]),
        .io_ack(ack[1]), .io_data(bus1), .busy(busy[1]), .proto_err(perr[1])
    );

    function automatic logic [7:0] get_bus(input int i);
        return (i == 0) ? bus0 : bus1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A strobe accepted at edge C completes on edge C+WS (ack for the
    // following cycle) and the responder is free again after edge C+WS+1.
    int         edge_no = 0;
    bit         inflight [2];
    int         cap_e [2];
    bit         m_wr [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_wd [2];
    logic [7:0] mmem [2][256];
    bit         known [2][256];
    bit         x_ack [2];
    bit         x_busy [2];
    bit         x_perr [2];
    bit         x_rdv [2];
    logic [7:0] x_rdata [2];

    always @(posedge clk) begin
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            x_perr[i] = 1'b0;
            x_rdv[i]  = 1'b0;
            if (!reset_n) begin
                inflight[i] = 1'b0;
            end else begin
                if (inflight[i] && edge_no == cap_e[i] + ws[i] + 1) begin
                    inflight[i] = 1'b0;
                end else if (!inflight[i]) begin
                    if (rd[i] && wr[i]) begin
                        x_perr[i] = 1'b1;
                    end else if (rd[i] || wr[i]) begin
                        inflight[i] = 1'b1;
                        cap_e[i]    = edge_no;
                        m_wr[i]     = wr[i];
                        m_addr[i]   = addr[i];
                        m_wd[i]     = tdat[i];
                    end
                end
                if (inflight[i] && edge_no == cap_e[i] + ws[i]) begin
                    if (m_wr[i]) begin
                        if (int'(m_addr[i]) < depth[i]) begin
                            mmem[i][m_addr[i]]  = m_wd[i];
                            known[i][m_addr[i]] = 1'b1;
                        end
                    end else if (int'(m_addr[i]) >= depth[i]) begin
                        x_rdv[i]   = 1'b1;
                        x_rdata[i] = 8'h00;
                    end else if (known[i][m_addr[i]]) begin
                        x_rdv[i]   = 1'b1;
                        x_rdata[i] = mmem[i][m_addr[i]];
                    end
                end
            end
            x_ack[i]  = inflight[i] && (edge_no == cap_e[i] + ws[i]);
            x_busy[i] = inflight[i] && (edge_no < cap_e[i] + ws[i]);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("ack%0d@%0d", i, edge_no), 32'(ack[i]), 32'(x_ack[i]));
            check_output($sformatf("busy%0d@%0d", i, edge_no), 32'(busy[i]), 32'(x_busy[i]));
            check_output($sformatf("perr%0d@%0d", i, edge_no), 32'(perr[i]), 32'(x_perr[i]));
            if (x_rdv[i]) begin
                check_output($sformatf("rdata%0d@%0d", i, edge_no), 32'(get_bus(i)), 32'(x_rdata[i]));
            end else if (!toe[i] && !(x_ack[i] && !m_wr[i])) begin
                check_output($sformatf("undriven%0d@%0d", i, edge_no), 32'(get_bus(i)), 32'hFF);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input int i, input logic r, input logic w,
                                  input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rd[i]   = r;
        wr[i]   = w;
        addr[i] = a;
        tdat[i] = d;
        toe[i]  = w;
        @(negedge clk);
        rd[i]  = 1'b0;
        wr[i]  = 1'b0;
        toe[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input int i, input logic [7:0] a, input logic [7:0] d, input string name);
        apply_stimulus(i, 1'b0, 1'b1, a, d);
        repeat (ws[i]) @(posedge clk);
        #2;
        check_output({name, "_ack"}, 32'(ack[i]), 32'd1);
        check_output({name, "_nodrive"}, 32'(get_bus(i)), 32'hFF);
        idle(1);
    endtask

    task automatic do_read(input int i, input logic [7:0] a, input logic [7:0] exp, input string name);
        apply_stimulus(i, 1'b1, 1'b0, a, 8'h00);
        repeat (ws[i]) @(posedge clk);
        #2;
        check_output({name, "_ack"}, 32'(ack[i]), 32'd1);
        check_output({name, "_data"}, 32'(get_bus(i)), 32'(exp));
        idle(1);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; toe[i] = 1'b0;
            addr[i] = 8'h00; tdat[i] = 8'h00;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_ack_a", 32'(ack[0]), 32'd0);
        check_output("reset_busy_a", 32'(busy[0]), 32'd0);
        check_output("reset_perr_b", 32'(perr[1]), 32'd0);
        check_output("reset_bus_a", 32'(bus0), 32'hFF);
        reset_n = 1'b1;
        idle(1);

        // A: write 0xA5 to 0x12; busy in the wait cycles, ack two edges later
        apply_stimulus(0, 1'b0, 1'b1, 8'h12, 8'hA5);
        #1;
        check_output("wr12_busy", 32'(busy[0]), 32'd1);
        check_output("wr12_noack", 32'(ack[0]), 32'd0);
        @(posedge clk); #2;
        check_output("wr12_noack2", 32'(ack[0]), 32'd0);
        @(posedge clk); #2;
        check_output("wr12_ack", 32'(ack[0]), 32'd1);
        check_output("wr12_busylow", 32'(busy[0]), 32'd0);
        check_output("wr12_nodrive", 32'(bus0), 32'hFF);
        idle(1);
        do_read(0, 8'h12, 8'hA5, "rd12");

        // A: rd 0x05 re-pulsed at relative edges 0 and 2 -> a single ack
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rd[0]   = (k == 0 || k == 2);
            addr[0] = 8'h05;
            @(posedge clk); #2;
            if (ack[0]) acks++;
        end
        rd[0] = 1'b0;
        check_output("repulse_acks", 32'(acks), 32'd1);
        check_output("repulse_busy", 32'(busy[0]), 32'd0);

        // A (DEPTH=128): out-of-range store dropped, load returns 0
        do_write(0, 8'h00, 8'h5A, "wr00");
        do_write(0, 8'h80, 8'h7E, "wr80");
        do_read(0, 8'h00, 8'h5A, "rd00");
        do_read(0, 8'h80, 8'h00, "rd80");

        // A: reset in WAIT aborts the second store to 0x20
        do_write(0, 8'h20, 8'h11, "wr20");
        apply_stimulus(0, 1'b0, 1'b1, 8'h20, 8'h3C);
        #1;
        check_output("abort_busy", 32'(busy[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("abort_busy_rst", 32'(busy[0]), 32'd0);
        check_output("abort_ack_rst", 32'(ack[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            if (ack[0]) acks++;
        end
        check_output("abort_noack", 32'(acks), 32'd0);
        do_read(0, 8'h20, 8'h11, "rd20");

        // B (WAIT_STATES=0): strobes at edges 0,1,2 -> acks after 0 and 2
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd[1]   = (k == 2);
            wr[1]   = (k == 0 || k == 1);
            toe[1]  = (k == 0 || k == 1);
            addr[1] = 8'h40;
            tdat[1] = (k == 0) ? 8'h99 : 8'h66;
            @(posedge clk); #2;
            if (ack[1]) acks++;
            if (k == 2) check_output("ws0_rd40", 32'(bus1), 32'h99);
        end
        rd[1] = 1'b0; wr[1] = 1'b0; toe[1] = 1'b0;
        check_output("ws0_acks", 32'(acks), 32'd2);

        // B: rd+wr together -> proto_err pulse, no ack, no write
        do_write(1, 8'h30, 8'h77, "wr30");
        apply_stimulus(1, 1'b1, 1'b1, 8'h30, 8'h55);
        #1;
        check_output("perr_pulse", 32'(perr[1]), 32'd1);
        check_output("perr_noack", 32'(ack[1]), 32'd0);
        @(posedge clk); #2;
        check_output("perr_drop", 32'(perr[1]), 32'd0);
        idle(1);
        do_read(1, 8'h30, 8'h77, "rd30");

        // B: reset during ACK, write already committed
        apply_stimulus(1, 1'b0, 1'b1, 8'h50, 8'hC3);
        #1;
        check_output("rstack_ack", 32'(ack[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("rstack_drop", 32'(ack[1]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        do_read(1, 8'h50, 8'hC3, "rd50");

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
